// File: rtl/hsr_gmac_pkg.sv
// Shared constants, encodings and FSM state type for the HSR GMAC init sequencer.
// Also holds the helper that builds each CSR write payload.
package hsr_gmac_pkg;

  localparam logic [7:0] CsrMacLo  = 8'h00;
  localparam logic [7:0] CsrMacHi  = 8'h04;
  localparam logic [7:0] CsrNodeId = 8'h08;
  localparam logic [7:0] CsrCtrl   = 8'h0C;
  localparam logic [7:0] CsrStatus = 8'h10;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  localparam int unsigned AxiIdWidth = 4;
  localparam logic [1:0]  IdxCtrl    = 2'd3;

  typedef enum logic [1:0] {
    ErrNone    = 2'd0,
    ErrBresp   = 2'd1,
    ErrRresp   = 2'd2,
    ErrTimeout = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdReq,
    StRdResp,
    StDone,
    StErr
  } state_e;

  // Write index 0..3 maps to MAC_LO, MAC_HI, NODE_ID, CTRL (consecutive words).
  function automatic logic [7:0] csr_offset(input logic [1:0] idx);
    return {4'h0, idx, 2'b00};
  endfunction

  function automatic logic [31:0] csr_wdata(input logic [1:0]  idx,
                                            input logic [47:0] mac,
                                            input logic [7:0]  id,
                                            input logic        hsr_en);
    logic [31:0] data;
    case (idx)
      2'd0:    data = mac[31:0];
      2'd1:    data = {16'h0, mac[47:32]};
      2'd2:    data = {24'h0, id};
      default: data = {30'h0, hsr_en, 1'b1};
    endcase
    return data;
  endfunction

endpackage

// File: rtl/hsr_gmac_init_seq_if.sv
// AXI4 single-beat bus bundle between the init sequencer (master) and the GMAC s_axi port.
interface hsr_gmac_init_seq_if
  import hsr_gmac_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  logic [AxiIdWidth-1:0]  AWID;
  logic [AddrWidth-1:0]   AWADDR;
  logic [7:0]             AWLEN;
  logic [2:0]             AWSIZE;
  logic [1:0]             AWBURST;
  logic                   AWVALID;
  logic                   AWREADY;
  logic [DataWidth-1:0]   WDATA;
  logic [DataWidth/8-1:0] WSTRB;
  logic                   WLAST;
  logic                   WVALID;
  logic                   WREADY;
  logic [AxiIdWidth-1:0]  BID;
  logic [1:0]             BRESP;
  logic                   BVALID;
  logic                   BREADY;
  logic [AxiIdWidth-1:0]  ARID;
  logic [AddrWidth-1:0]   ARADDR;
  logic [7:0]             ARLEN;
  logic [2:0]             ARSIZE;
  logic [1:0]             ARBURST;
  logic                   ARVALID;
  logic                   ARREADY;
  logic [AxiIdWidth-1:0]  RID;
  logic [DataWidth-1:0]   RDATA;
  logic [1:0]             RRESP;
  logic                   RLAST;
  logic                   RVALID;
  logic                   RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID,
    output BREADY, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  AWREADY, WREADY, BID, BRESP, BVALID, ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID,
    input  BREADY, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output AWREADY, WREADY, BID, BRESP, BVALID, ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/hsr_gmac_init_seq.sv
// Standalone GMAC bring-up: writes MAC/ID/CTRL over AXI4, then polls STATUS until ready
// or the poll budget runs out.
module hsr_gmac_init_seq
  import hsr_gmac_pkg::*;
#(
  parameter int unsigned AXI_WIDTH_AD    = 32,
  parameter int unsigned AXI_WIDTH_DA    = 32,
  parameter int unsigned AXI_MST_ID      = 0,
  parameter logic [31:0] ADDR_START_GMAC = 32'h4300_0000,
  parameter bit          HSR_ENABLE      = 1'b1,
  parameter int unsigned POLL_LIMIT      = 1024
) (
  input  logic                       ACLK,
  input  logic                       RESET,
  input  logic                       start,
  input  logic [47:0]                mac_addr,
  input  logic [7:0]                 hsr_id,
  hsr_gmac_init_seq_if.master        axi,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [1:0]                 err_code,
  output logic [15:0]                poll_cnt
);

  localparam logic [AXI_WIDTH_AD-1:0] Base = AXI_WIDTH_AD'(ADDR_START_GMAC);

  state_e                  state_q, state_d;
  err_code_e               err_q, err_d;
  logic [1:0]              idx_q, idx_d, idx_nxt;
  logic [15:0]             poll_q, poll_d;
  logic [47:0]             mac_q, mac_d;
  logic [7:0]              id_q, id_d;
  logic [AXI_WIDTH_AD-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [AXI_WIDTH_DA-1:0] wdata_q, wdata_d;
  logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                    awvalid, wvalid, aw_hs, w_hs, idle_like;
  logic                    unused_rsp;

  assign idle_like = (state_q == StIdle) || (state_q == StDone) || (state_q == StErr);
  // AW and W drop independently once their own handshake has been seen.
  assign awvalid   = (state_q == StWrReq) && !aw_done_q;
  assign wvalid    = (state_q == StWrReq) && !w_done_q;
  assign aw_hs     = awvalid && axi.AWREADY;
  assign w_hs      = wvalid && axi.WREADY;
  assign idx_nxt   = idx_q + 2'd1;

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    idx_d     = idx_q;
    poll_d    = poll_q;
    mac_d     = mac_q;
    id_d      = id_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d   = StWrReq;
          err_d     = ErrNone;
          idx_d     = 2'd0;
          poll_d    = 16'd0;
          mac_d     = mac_addr;
          id_d      = hsr_id;
          awaddr_d  = Base + AXI_WIDTH_AD'(csr_offset(2'd0));
          wdata_d   = AXI_WIDTH_DA'(csr_wdata(2'd0, mac_addr, hsr_id, HSR_ENABLE));
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      StWrReq: begin
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) state_d = StWrResp;
      end
      StWrResp: begin
        if (axi.BVALID) begin
          if (axi.BRESP != RespOkay) begin
            state_d = StErr;
            err_d   = ErrBresp;
          end else if (idx_q == IdxCtrl) begin
            state_d  = StRdReq;
            araddr_d = Base + AXI_WIDTH_AD'(CsrStatus);
          end else begin
            state_d   = StWrReq;
            idx_d     = idx_nxt;
            awaddr_d  = Base + AXI_WIDTH_AD'(csr_offset(idx_nxt));
            wdata_d   = AXI_WIDTH_DA'(csr_wdata(idx_nxt, mac_q, id_q, HSR_ENABLE));
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end
        end
      end
      StRdReq: begin
        if (axi.ARREADY) begin
          poll_d  = poll_q + 16'd1;
          state_d = StRdResp;
        end
      end
      StRdResp: begin
        if (axi.RVALID) begin
          if (axi.RRESP != RespOkay) begin
            state_d = StErr;
            err_d   = ErrRresp;
          end else if (axi.RDATA[0]) begin
            state_d = StDone;
          end else if (poll_q == 16'(POLL_LIMIT)) begin
            state_d = StErr;
            err_d   = ErrTimeout;
          end else begin
            state_d = StRdReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      err_q     <= ErrNone;
      idx_q     <= 2'd0;
      poll_q    <= 16'd0;
      mac_q     <= 48'd0;
      id_q      <= 8'd0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      poll_q    <= poll_d;
      mac_q     <= mac_d;
      id_q      <= id_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign axi.AWID    = AxiIdWidth'(AXI_MST_ID);
  assign axi.AWADDR  = awaddr_q;
  assign axi.AWLEN   = 8'd0;
  assign axi.AWSIZE  = 3'b010;
  assign axi.AWBURST = 2'b01;
  assign axi.AWVALID = awvalid;
  assign axi.WDATA   = wdata_q;
  assign axi.WSTRB   = '1;
  assign axi.WLAST   = 1'b1;
  assign axi.WVALID  = wvalid;
  assign axi.BREADY  = (state_q == StWrResp);
  assign axi.ARID    = AxiIdWidth'(AXI_MST_ID);
  assign axi.ARADDR  = araddr_q;
  assign axi.ARLEN   = 8'd0;
  assign axi.ARSIZE  = 3'b010;
  assign axi.ARBURST = 2'b01;
  assign axi.ARVALID = (state_q == StRdReq);
  assign axi.RREADY  = (state_q == StRdResp);

  assign busy     = !idle_like;
  assign done     = (state_q == StDone);
  assign error    = (state_q == StErr);
  assign err_code = err_q;
  assign poll_cnt = poll_q;

  // Response IDs, RLAST and the non-ready STATUS bits carry nothing for single-beat use.
  assign unused_rsp = ^{axi.BID, axi.RID, axi.RLAST, axi.RDATA[AXI_WIDTH_DA-1:1]};

endmodule

// File: tb/tb_hsr_gmac_init_seq.sv
// Bench for hsr_gmac_init_seq: a delay-configurable AXI slave, a table of scenarios and
// randomized runs checked against a plain model of the expected CSR traffic.
module tb_hsr_gmac_init_seq;
  localparam int Limit = 4;

  logic        ACLK, RESET, start, busy, done, error;
  logic [47:0] mac_addr;
  logic [7:0]  hsr_id;
  logic [1:0]  err_code;
  logic [15:0] poll_cnt;

  hsr_gmac_init_seq_if axi ();

  hsr_gmac_init_seq #(.POLL_LIMIT(Limit)) dut (
    .ACLK(ACLK), .RESET(RESET), .start(start), .mac_addr(mac_addr), .hsr_id(hsr_id),
    .axi(axi), .busy(busy), .done(done), .error(error), .err_code(err_code),
    .poll_cnt(poll_cnt)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  typedef struct {
    string       name;
    logic [47:0] mac;
    logic [7:0]  id;
    int aw_lo, aw_hi, w_lo, w_hi, b_dly, r_dly, berr_idx, ready_at, rerr_at;
    bit busy_start;
    bit exp_done;
    int exp_code, exp_poll, exp_writes, exp_cyc;
  } scn_t;

  int n_chk = 0, n_fail = 0;
  int scn_id = 0;
  int aw_lo, aw_hi, w_lo, w_hi, b_dly, r_dly, berr_idx, ready_at, rerr_at;

  // Slave-owned observation state.
  logic [31:0] aw_log[$], w_log[$];
  int n_ar, viol;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic logic [31:0] model_wdata(int i, logic [47:0] mac, logic [7:0] id);
    case (i)
      0:       return mac[31:0];
      1:       return {16'h0, mac[47:32]};
      2:       return {24'h0, id};
      default: return 32'h0000_0003;
    endcase
  endfunction

  // AXI slave: logs handshakes at the edge, drives READY/response #1 after it.
  initial begin : slave
    int last_id = 0, aw_wait = 0, w_wait = 0, b_wait = 0, r_wait = 0, n_bsched = 0;
    bit pend_b = 0, pend_r = 0, b_taken = 0, r_taken = 0, rst_seen = 0;
    bit aw_hold = 0, w_hold = 0, ar_hold = 0;
    logic [31:0] aw_hold_v = 0, w_hold_v = 0, ar_hold_v = 0, rd;
    logic [1:0] bresp_nxt = 0;
    n_ar = 0; viol = 0;
    {axi.AWREADY, axi.WREADY, axi.BVALID, axi.ARREADY, axi.RVALID, axi.RLAST} = '0;
    axi.BID = '0; axi.BRESP = '0; axi.RID = '0; axi.RDATA = '0; axi.RRESP = '0;
    forever begin
      @(posedge ACLK);
      rst_seen = RESET;
      if (RESET || scn_id != last_id) begin
        last_id = scn_id;
        aw_log.delete(); w_log.delete();
        n_ar = 0; viol = 0; n_bsched = 0;
        pend_b = 0; pend_r = 0; aw_hold = 0; w_hold = 0; ar_hold = 0;
      end
      if (!RESET) begin
        if (aw_hold && (!axi.AWVALID || axi.AWADDR != aw_hold_v)) viol++;
        if (w_hold && (!axi.WVALID || axi.WDATA != w_hold_v)) viol++;
        if (ar_hold && (!axi.ARVALID || axi.ARADDR != ar_hold_v)) viol++;
        aw_hold = axi.AWVALID && !axi.AWREADY; aw_hold_v = axi.AWADDR;
        w_hold  = axi.WVALID && !axi.WREADY;   w_hold_v  = axi.WDATA;
        ar_hold = axi.ARVALID && !axi.ARREADY; ar_hold_v = axi.ARADDR;
        b_taken = axi.BVALID && axi.BREADY;
        r_taken = axi.RVALID && axi.RREADY;
        if (axi.AWVALID && axi.AWREADY) begin
          aw_log.push_back(axi.AWADDR);
          if (axi.AWLEN != 0 || axi.AWSIZE != 3'b010 || axi.AWBURST != 2'b01) viol++;
        end
        if (axi.WVALID && axi.WREADY) begin
          w_log.push_back(axi.WDATA);
          if (axi.WSTRB != 4'hF || !axi.WLAST) viol++;
        end
        if (axi.ARVALID && axi.ARREADY) begin
          n_ar++;
          if (axi.ARADDR != 32'h4300_0010 || axi.ARLEN != 0) viol++;
          pend_r = 1; r_wait = r_dly;
        end
      end
      #1;
      if (rst_seen) begin
        {axi.AWREADY, axi.WREADY, axi.BVALID, axi.ARREADY, axi.RVALID} = '0;
      end else begin
        if (axi.AWVALID) begin
          if (aw_wait > 0) begin axi.AWREADY = 0; aw_wait--; end else axi.AWREADY = 1;
        end else begin
          axi.AWREADY = 0; aw_wait = $urandom_range(aw_hi, aw_lo);
        end
        if (axi.WVALID) begin
          if (w_wait > 0) begin axi.WREADY = 0; w_wait--; end else axi.WREADY = 1;
        end else begin
          axi.WREADY = 0; w_wait = $urandom_range(w_hi, w_lo);
        end
        axi.ARREADY = 1;
        if (b_taken) axi.BVALID = 0;
        if (r_taken) axi.RVALID = 0;
        if (aw_log.size() > n_bsched && w_log.size() > n_bsched) begin
          pend_b = 1; b_wait = b_dly;
          bresp_nxt = (n_bsched == berr_idx) ? 2'b10 : 2'b00;
          n_bsched++;
        end
        if (pend_b) begin
          if (b_wait == 0) begin
            axi.BVALID = 1; axi.BRESP = bresp_nxt; axi.BID = 4'($urandom); pend_b = 0;
          end else b_wait--;
        end
        if (pend_r) begin
          if (r_wait == 0) begin
            rd = $urandom;
            rd[0] = (ready_at != 0 && n_ar >= ready_at);
            axi.RDATA = rd; axi.RLAST = 1; axi.RVALID = 1;
            axi.RRESP = (n_ar == rerr_at) ? 2'b10 : 2'b00;
            pend_r = 0;
          end else r_wait--;
        end
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, ".awvalid"}, axi.AWVALID, 0);
    chk({tag, ".wvalid"}, axi.WVALID, 0);
    chk({tag, ".arvalid"}, axi.ARVALID, 0);
    chk({tag, ".bready"}, axi.BREADY, 0);
    chk({tag, ".rready"}, axi.RREADY, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".error"}, error, 0);
    chk({tag, ".err_code"}, err_code, 0);
    chk({tag, ".poll_cnt"}, poll_cnt, 0);
    chk({tag, ".awaddr"}, axi.AWADDR, 0);
    chk({tag, ".wdata"}, axi.WDATA, 0);
    chk({tag, ".araddr"}, axi.ARADDR, 0);
  endtask

  task automatic configure(input scn_t s);
    aw_lo = s.aw_lo; aw_hi = s.aw_hi; w_lo = s.w_lo; w_hi = s.w_hi;
    b_dly = s.b_dly; r_dly = s.r_dly; berr_idx = s.berr_idx;
    ready_at = s.ready_at; rerr_at = s.rerr_at;
  endtask

  task automatic run_scn(input scn_t s);
    int cyc, nw;
    bit sent;
    scn_id++;
    configure(s);
    @(posedge ACLK); #1;
    mac_addr = s.mac; hsr_id = s.id; start = 1;
    @(posedge ACLK); #1;
    start = 0; mac_addr = {16'($urandom), 32'($urandom)}; hsr_id = 8'($urandom);
    cyc = 0; sent = 0;
    while (!(done || error) && cyc < 300) begin
      if (s.busy_start && !sent && axi.RREADY) begin start = 1; sent = 1; end
      @(posedge ACLK); #1;
      start = 0; cyc++;
    end
    chk({s.name, ".finished"}, cyc < 300, 1);
    if (s.exp_cyc >= 0) chk({s.name, ".cycles"}, cyc, s.exp_cyc);
    chk({s.name, ".done"}, done, s.exp_done);
    chk({s.name, ".error"}, error, !s.exp_done);
    chk({s.name, ".err_code"}, err_code, s.exp_code);
    chk({s.name, ".poll_cnt"}, poll_cnt, s.exp_poll);
    chk({s.name, ".busy"}, busy, 0);
    chk({s.name, ".n_aw"}, aw_log.size(), s.exp_writes);
    chk({s.name, ".n_w"}, w_log.size(), s.exp_writes);
    chk({s.name, ".n_ar"}, n_ar, s.exp_poll);
    chk({s.name, ".protocol"}, viol, 0);
    nw = (aw_log.size() < s.exp_writes) ? aw_log.size() : s.exp_writes;
    for (int i = 0; i < nw; i++)
      chk($sformatf("%s.awaddr%0d", s.name, i), aw_log[i], 32'h4300_0000 + 32'(4 * i));
    nw = (w_log.size() < s.exp_writes) ? w_log.size() : s.exp_writes;
    for (int i = 0; i < nw; i++)
      chk($sformatf("%s.wdata%0d", s.name, i), w_log[i], model_wdata(i, s.mac, s.id));
  endtask

  function automatic scn_t mk(string nm, logic [47:0] mac, logic [7:0] id,
                              int awl, int awh, int wl, int wh, int bd, int rd,
                              int be, int ra, int re, bit bs,
                              bit ed, int ec, int ep, int ew, int cy);
    scn_t s;
    s.name = nm; s.mac = mac; s.id = id;
    s.aw_lo = awl; s.aw_hi = awh; s.w_lo = wl; s.w_hi = wh; s.b_dly = bd; s.r_dly = rd;
    s.berr_idx = be; s.ready_at = ra; s.rerr_at = re; s.busy_start = bs;
    s.exp_done = ed; s.exp_code = ec; s.exp_poll = ep; s.exp_writes = ew; s.exp_cyc = cy;
    return s;
  endfunction

  // Reference expectations from the rules: a bad BRESP stops after that write, else the
  // first ready STATUS wins unless the poll budget is exhausted first.
  function automatic scn_t model_fill(scn_t s);
    scn_t r = s;
    r.exp_cyc = -1;
    if (s.berr_idx >= 0) begin
      r.exp_done = 0; r.exp_code = 1; r.exp_poll = 0; r.exp_writes = s.berr_idx + 1;
    end else if (s.ready_at >= 1 && s.ready_at <= Limit) begin
      r.exp_done = 1; r.exp_code = 0; r.exp_poll = s.ready_at; r.exp_writes = 4;
    end else begin
      r.exp_done = 0; r.exp_code = 3; r.exp_poll = Limit; r.exp_writes = 4;
    end
    return r;
  endfunction

  scn_t tbl[8];

  initial begin
    scn_t s;
    int cyc;
    tbl[0] = mk("happy", 48'hF0_12_34_56_78_05, 8'd5, 0,0,0,0, 1,1, -1,1,0, 0, 1,0,1,4, 15);
    tbl[1] = mk("w_late3", 48'h0123_4567_89AB, 8'hA5, 0,0,3,3, 1,1, -1,2,0, 0, 1,0,2,4, -1);
    tbl[2] = mk("aw_late3", 48'hDEAD_BEEF_0001, 8'h11, 3,3,0,0, 0,0, -1,1,0, 0, 1,0,1,4, -1);
    tbl[3] = mk("skew", 48'hCAFE_0000_1234, 8'h7E, 0,5,0,5, 2,2, -1,3,0, 0, 1,0,3,4, -1);
    tbl[4] = mk("timeout", 48'h1111_2222_3333, 8'h01, 0,0,0,0, 1,1, -1,0,0, 0, 0,3,4,4, -1);
    tbl[5] = mk("bresp_err", 48'hABCD_EF01_2345, 8'h22, 0,1,0,1, 1,1, 1,1,0, 0, 0,1,0,2, -1);
    tbl[6] = mk("rresp_err", 48'h5555_AAAA_5555, 8'h33, 0,0,0,0, 0,1, -1,0,2, 0, 0,2,2,4, -1);
    tbl[7] = mk("busy_start", 48'h0F0F_F0F0_1234, 8'h44, 0,0,0,0, 1,3, -1,2,0, 1, 1,0,2,4, -1);

    RESET = 1; start = 0; mac_addr = '0; hsr_id = '0;
    configure(tbl[0]);
    repeat (3) @(posedge ACLK);
    #1;
    chk_reset("por");
    RESET = 0;

    foreach (tbl[i]) run_scn(tbl[i]);

    // Reset while waiting for the NODE_ID write response, then a clean replay.
    s = tbl[0];
    s.b_dly = 6;
    scn_id++;
    configure(s);
    @(posedge ACLK); #1;
    mac_addr = 48'h0A0B_0C0D_0E0F; hsr_id = 8'h66; start = 1;
    @(posedge ACLK); #1;
    start = 0; cyc = 0;
    while (!(aw_log.size() >= 3 && w_log.size() >= 3) && cyc < 100) begin
      @(posedge ACLK); #1;
      cyc++;
    end
    chk("midrst.reached", cyc < 100, 1);
    chk("midrst.busy_before", busy, 1);
    chk("midrst.bready_before", axi.BREADY, 1);
    RESET = 1;
    @(posedge ACLK); #1;
    chk_reset("midrst");
    RESET = 0;
    s = tbl[0];
    s.name = "replay";
    run_scn(s);

    for (int k = 0; k < 12; k++) begin
      s = mk($sformatf("rand%0d", k), {16'($urandom), 32'($urandom)}, 8'($urandom),
             0, $urandom_range(0, 5), 0, $urandom_range(0, 5),
             $urandom_range(0, 3), $urandom_range(0, 3),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
             $urandom_range(0, 5), 0, 0, 0, 0, 0, 0, -1);
      run_scn(model_fill(s));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
